// File: rtl/imem_byte_writer.sv
// Byte-addressed instruction store: accepts 32-bit words over valid/ready and commits
// them big-endian, one byte per cycle; a combinational fetch port reads four bytes back.
module imem_byte_writer #(
    parameter int MEM_BYTES = 100,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              wr_err,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_inst
);

    localparam int IDX_W = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [1:0]        cnt_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       data_reg;
    logic              err_reg, err_next;
    logic              load, write_en;
    logic [7:0]        mem [MEM_BYTES];

    logic [ADDR_W:0]   wr_last;
    logic              in_range;
    logic [ADDR_W-1:0] wr_byte_addr;
    logic [IDX_W-1:0]  wr_idx;
    logic              wr_idx_ok;
    logic [1:0]        byte_sh;
    logic [7:0]        wr_byte;

    // Range check is one bit wider than the bus so addresses near the top cannot wrap.
    assign wr_last  = {1'b0, wr_addr} + (ADDR_W+1)'(3);
    assign in_range = (wr_last <= (ADDR_W+1)'(MEM_BYTES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        write_en   = 1'b0;
        err_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (wr_valid) begin
                    if (in_range) begin
                        load       = 1'b1;
                        state_next = WRITE;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            WRITE: begin
                write_en = 1'b1;
                if (cnt_reg == 2'd3) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign wr_ready = (state_reg == IDLE);
    assign busy     = (state_reg == WRITE);
    assign done     = (state_reg == DONE);
    assign wr_err   = err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg <= '0;
            data_reg <= '0;
            cnt_reg  <= 2'd0;
            err_reg  <= 1'b0;
        end else begin
            err_reg <= err_next;
            if (load) begin
                addr_reg <= wr_addr;
                data_reg <= wr_data;
                cnt_reg  <= 2'd0;
            end else if (write_en) begin
                cnt_reg <= cnt_reg + 2'd1;
            end
        end
    end

    // Byte k of the word is the k-th most significant byte.
    assign byte_sh      = 2'd3 - cnt_reg;
    assign wr_byte      = data_reg[{byte_sh, 3'b000} +: 8];
    assign wr_byte_addr = addr_reg + ADDR_W'(cnt_reg);
    assign wr_idx       = wr_byte_addr[IDX_W-1:0];
    assign wr_idx_ok    = (wr_byte_addr < ADDR_W'(MEM_BYTES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_BYTES; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (write_en && wr_idx_ok) begin
            mem[wr_idx] <= wr_byte;
        end
    end

    // Fetch: each byte lane computes its own address; anything past the store reads zero.
    for (genvar gi = 0; gi < 4; gi++) begin : g_fetch
        logic [ADDR_W:0] byte_addr;
        assign byte_addr = {1'b0, rd_addr} + (ADDR_W+1)'(gi);
        assign rd_inst[31-8*gi -: 8] = (byte_addr < (ADDR_W+1)'(MEM_BYTES))
                                       ? mem[byte_addr[IDX_W-1:0]] : 8'h00;
    end

endmodule

// File: tb/tb_imem_byte_writer.sv
// Bench for imem_byte_writer: directed writes, completion events checked by a scoreboard
// monitor, fetch-port values checked against hand-computed words.
module tb_imem_byte_writer;

    logic        clk;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        wr_err;
    logic [31:0] rd_addr;
    logic [31:0] rd_inst;

    int total = 0;
    int bad   = 0;
    int sb_q[$];   // expected events: 0 = done, 1 = wr_err

    imem_byte_writer #(.MEM_BYTES(100), .ADDR_W(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .wr_err   (wr_err),
        .rd_addr  (rd_addr),
        .rd_inst  (rd_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Monitor: whenever the DUT raises done or wr_err, pop and compare the expected event.
    always @(negedge clk) begin
        if (rst_n && (done || wr_err)) begin
            chk("done_err_exclusive", {31'd0, done && wr_err}, 32'd0);
            if (sb_q.size() == 0) begin
                chk("unexpected_event", {31'd0, wr_err}, {31'd0, done});
                total++;
                bad++;
                $display("FAIL unexpected_event actual=done%0d/err%0d required=none", done, wr_err);
            end else begin
                int exp_kind;
                exp_kind = sb_q.pop_front();
                chk("event_kind", {31'd0, wr_err}, exp_kind[31:0]);
                $display("event %s seen", wr_err ? "wr_err" : "done");
            end
        end
    end

    task automatic fetch(input logic [31:0] a, input logic [31:0] exp, input string nm);
        rd_addr = a;
        #1;
        chk(nm, rd_inst, exp);
    endtask

    // Present a request, hold it until wr_ready, return 1 time unit after the accept edge.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int kind, input bit push);
        int n;
        n = 0;
        wr_addr  = a;
        wr_data  = d;
        wr_valid = 1'b1;
        while (!wr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", {31'd0, n >= 20}, 32'd0);
        if (push) sb_q.push_back(kind);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        $display("write addr=%0d data=%h issued", a, d);
    endtask

    // Four busy cycles then one done cycle; optionally trace the fetch word each cycle.
    task automatic wait_done(input bit trace, input logic [31:0] t0, input logic [31:0] t1,
                             input logic [31:0] t2, input logic [31:0] t3, input logic [31:0] t4);
        logic [31:0] tv [5];
        tv[0] = t0; tv[1] = t1; tv[2] = t2; tv[3] = t3; tv[4] = t4;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("busy_cycle", {31'd0, busy}, {31'd0, k <= 4});
            chk("done_cycle", {31'd0, done}, {31'd0, k == 5});
            if (k <= 4) chk("ready_low", {31'd0, wr_ready}, 32'd0);
            if (trace) chk("partial_word", rd_inst, tv[k-1]);
        end
    endtask

    initial begin
        int n;
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_addr  = '0;
        repeat (2) @(negedge clk);
        fetch(32'd0, 32'h0000_0000, "reset_rd0");
        fetch(32'd96, 32'h0000_0000, "reset_rd96");
        chk("reset_ready", {31'd0, wr_ready}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_err", {31'd0, wr_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic word write
        do_write(32'd0, 32'h3408_000B, 0, 1'b1);
        wait_done(1'b0, '0, '0, '0, '0, '0);
        fetch(32'd0, 32'h3408_000B, "word_at_0");
        fetch(32'd3, 32'h0B00_0000, "byte3_at_3");

        // Byte-by-byte progression visible on the fetch port
        rd_addr = 32'd12;
        do_write(32'd12, 32'h0008_8880, 0, 1'b1);
        wait_done(1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0008_0000, 32'h0008_8800, 32'h0008_8880);

        // Out-of-range request rejected, then the last legal word accepted
        do_write(32'd97, 32'hDEAD_BEEF, 1, 1'b1);
        @(negedge clk);
        chk("err_pulse", {31'd0, wr_err}, 32'd1);
        chk("err_ready", {31'd0, wr_ready}, 32'd1);
        chk("err_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("err_one_cycle", {31'd0, wr_err}, 32'd0);
        chk("err_no_done", {31'd0, done}, 32'd0);
        fetch(32'd96, 32'h0000_0000, "err_mem_unchanged");
        do_write(32'd96, 32'h1122_3344, 0, 1'b1);
        wait_done(1'b0, '0, '0, '0, '0, '0);
        fetch(32'd96, 32'h1122_3344, "word_at_96");
        fetch(32'd97, 32'h2233_4400, "fetch_past_end");

        // Request held during WRITE is ignored until IDLE
        do_write(32'd0, 32'hAABB_CCDD, 0, 1'b1);
        wr_addr  = 32'd4;
        wr_data  = 32'h5566_7788;
        wr_valid = 1'b1;
        sb_q.push_back(0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wr_ready && n < 20);
        chk("held_accept_delay", n, 32'd6);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        $display("write addr=4 data=55667788 issued (held)");
        wait_done(1'b0, '0, '0, '0, '0, '0);
        fetch(32'd0, 32'hAABB_CCDD, "overwrite_at_0");
        fetch(32'd4, 32'h5566_7788, "word_at_4");
        fetch(32'd2, 32'hCCDD_5566, "straddle_at_2");

        // Reset in the middle of a write aborts it and clears memory
        rd_addr = 32'd8;
        do_write(32'd8, 32'h9988_7766, 0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("pre_reset_partial", rd_inst, 32'h9988_0000);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_ready", {31'd0, wr_ready}, 32'd1);
        chk("abort_done", {31'd0, done}, 32'd0);
        fetch(32'd8, 32'h0000_0000, "abort_rd8");
        fetch(32'd0, 32'h0000_0000, "abort_rd0");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Recovery after reset
        do_write(32'd4, 32'h0102_0304, 0, 1'b1);
        wait_done(1'b0, '0, '0, '0, '0, '0);
        fetch(32'd4, 32'h0102_0304, "recover_at_4");
        @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
